// File: rtl/bpred_pkg.sv
// Shared predictor types and constants for branch_predict_next_pc.
// Counter encodings, reset/allocation values and the fetch step size.
package bpred_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_t;

    localparam cnt_t CNT_RESET = CNT_WNT;
    localparam cnt_t CNT_ALLOC = CNT_WT;
    localparam int unsigned INST_SIZE = 4;

    typedef struct packed {
        logic valid;
        cnt_t cnt;
    } bpred_entry_t;

    function automatic cnt_t cnt_inc(input cnt_t c);
        cnt_t r;
        unique case (c)
            CNT_SNT: r = CNT_WNT;
            CNT_WNT: r = CNT_WT;
            default: r = CNT_ST;
        endcase
        return r;
    endfunction

    function automatic cnt_t cnt_dec(input cnt_t c);
        cnt_t r;
        unique case (c)
            CNT_ST:  r = CNT_WT;
            CNT_WT:  r = CNT_WNT;
            default: r = CNT_SNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bpred_table.sv
// Direct-mapped branch history table: one combinational read port for
// lookup, one training write port; reads see pre-update contents.
module bpred_table
    import bpred_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] rd_addr_i,
    output logic            rd_taken_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            wr_valid_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic            wr_taken_i,
    input  logic [XLEN-1:0] wr_target_i
);

    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned TW = XLEN - IW - 2;

    bpred_entry_t    ent_q [ENTRIES];
    logic [TW-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0] tgt_q [ENTRIES];

    logic [IW-1:0] rd_idx;
    logic [TW-1:0] rd_tag;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;
    logic          wr_hit;
    logic          we;
    bpred_entry_t    ent_d;
    logic [TW-1:0]   tag_d;
    logic [XLEN-1:0] tgt_d;
    logic            unused_lo;

    assign rd_idx = rd_addr_i[IW+1:2];
    assign rd_tag = rd_addr_i[XLEN-1:IW+2];
    assign wr_idx = wr_pc_i[IW+1:2];
    assign wr_tag = wr_pc_i[XLEN-1:IW+2];
    assign unused_lo = ^{rd_addr_i[1:0], wr_pc_i[1:0]};

    assign rd_taken_o  = ent_q[rd_idx].valid
                      && (tag_q[rd_idx] == rd_tag)
                      && ent_q[rd_idx].cnt[1];
    assign rd_target_o = tgt_q[rd_idx];

    assign wr_hit = ent_q[wr_idx].valid && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        we    = 1'b0;
        ent_d = ent_q[wr_idx];
        tag_d = tag_q[wr_idx];
        tgt_d = tgt_q[wr_idx];
        if (wr_valid_i) begin
            if (wr_hit) begin
                we = 1'b1;
                if (wr_taken_i) begin
                    ent_d.cnt = cnt_inc(ent_q[wr_idx].cnt);
                    tgt_d     = wr_target_i;
                end else begin
                    ent_d.cnt = cnt_dec(ent_q[wr_idx].cnt);
                end
            end else if (wr_taken_i) begin
                // Miss on a taken branch replaces whatever held the slot.
                we    = 1'b1;
                ent_d = '{valid: 1'b1, cnt: CNT_ALLOC};
                tag_d = wr_tag;
                tgt_d = wr_target_i;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ent_q[i] <= '{valid: 1'b0, cnt: CNT_RESET};
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (we) begin
            ent_q[wr_idx] <= ent_d;
            tag_q[wr_idx] <= tag_d;
            tgt_q[wr_idx] <= tgt_d;
        end
    end

endmodule

// File: rtl/branch_predict_next_pc.sv
// Next-fetch-PC selection with optional bimodal predictor.
// Predictor present only when BPRED_EN is defined.
module branch_predict_next_pc
    import bpred_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] inst_address,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    logic            lk_taken;
    logic [XLEN-1:0] lk_target;
    logic [XLEN-1:0] seq_pc;

    assign seq_pc = inst_address + XLEN'(INST_SIZE);

`ifdef BPRED_EN
    logic            pred_taken_q, pred_taken_d;
    logic [XLEN-1:0] pred_target_q, pred_target_d;

    bpred_table #(
        .ENTRIES (BHT_ENTRIES),
        .XLEN    (XLEN)
    ) u_table (
        .clock       (clock),
        .reset       (reset),
        .rd_addr_i   (inst_address),
        .rd_taken_o  (lk_taken),
        .rd_target_o (lk_target),
        .wr_valid_i  (upd_valid),
        .wr_pc_i     (upd_pc),
        .wr_taken_i  (upd_taken),
        .wr_target_i (upd_target)
    );

    always_comb begin
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (redirect_valid) begin
            pred_taken_d  = 1'b0;
            pred_target_d = '0;
        end else if (!stall) begin
            pred_taken_d  = lk_taken;
            pred_target_d = lk_taken ? lk_target : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
`else
    logic unused_upd;

    assign unused_upd  = ^{clock, upd_valid, upd_pc,
                           upd_taken, upd_target};
    assign lk_taken    = 1'b0;
    assign lk_target   = '0;
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
`endif

    always_comb begin
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = inst_address;
        end else if (lk_taken) begin
            next_pc = lk_target;
        end else begin
            next_pc = seq_pc;
        end
    end

endmodule

// File: tb/tb_branch_predict_next_pc.sv
// Scoreboard bench for branch_predict_next_pc; reference model follows
// the BPRED_EN setting of the build.
module tb_branch_predict_next_pc;

`ifdef BPRED_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    localparam int N  = 16;
    localparam int LG = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inst_address;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    branch_predict_next_pc #(.BHT_ENTRIES(N), .XLEN(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .inst_address   (inst_address),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .next_pc        (next_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] npc;
        logic        ptk;
        logic [31:0] ptgt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    bit          m_v   [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];
    logic        m_ptk;
    logic [31:0] m_ptgt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_ptk = 0; m_ptgt = 0;
    endtask

    task automatic cyc(input logic [31:0] pc, input logic st,
                       input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg);
        int idx;
        bit hit, tk;
        exp_t e;
        @(negedge clock);
        inst_address = pc; stall = st;
        redirect_valid = rv; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        idx = int'((pc >> 2) % N);
        hit = EN && m_v[idx] && (m_tag[idx] == (pc >> (LG + 2)));
        tk  = hit && (m_ctr[idx] >= 2);
        if (rv)      e.npc = rpc;
        else if (st) e.npc = pc;
        else if (tk) e.npc = m_tgt[idx];
        else         e.npc = pc + 32'd4;
        if (rv) begin
            m_ptk = 0; m_ptgt = 0;
        end else if (!st) begin
            m_ptk = tk; m_ptgt = tk ? m_tgt[idx] : 32'd0;
        end
        e.ptk = m_ptk; e.ptgt = m_ptgt;
        q.push_back(e);
        if (EN && uv) begin
            idx = int'((upc >> 2) % N);
            if (m_v[idx] && m_tag[idx] == (upc >> (LG + 2))) begin
                if (ut) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = utg;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (ut) begin
                m_v[idx] = 1; m_tag[idx] = upc >> (LG + 2);
                m_tgt[idx] = utg; m_ctr[idx] = 2;
            end
        end
    endtask

    task automatic fetch(input logic [31:0] pc);
        cyc(pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utg);
        cyc(pc, 0, 0, 0, 1, upc, ut, utg);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("next_pc", next_pc, e.npc);
                @(posedge clock);
                #1;
                chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.ptk});
                chk("pred_target", pred_target, e.ptgt);
            end
        end
    end

    function automatic logic [31:0] rpick();
        logic [31:0] pool [5];
        pool[0] = 32'h40; pool[1] = 32'h80; pool[2] = 32'h44;
        pool[3] = 32'hC0; pool[4] = 32'h100;
        if ($urandom_range(0, 5) == 5) return $urandom();
        return pool[$urandom_range(0, 4)] | 32'($urandom_range(0, 3));
    endfunction

    initial begin : stim
        reset = 0; inst_address = 32'hFFFF_FFFC; stall = 0;
        redirect_valid = 0; redirect_pc = 0;
        upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h100;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        upd_valid = 0;
        @(negedge clock);
        #1 reset = 1;

        fetch(32'hFFFF_FFFC);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);

        train(32'hC, 32'h40, 1, 32'h100);
        fetch(32'h40);
        fetch(32'h100);
        train(32'h104, 32'h40, 0, 0);
        train(32'h108, 32'h40, 0, 0);
        fetch(32'h40);
        train(32'h44, 32'h40, 0, 0);
        fetch(32'h40);
        train(32'h44, 32'h40, 1, 32'h100);
        train(32'h48, 32'h40, 1, 32'h100);
        fetch(32'h40);
        cyc(32'h40, 1, 1, 32'h200, 0, 0, 0, 0);
        fetch(32'h80);
        train(32'h200, 32'h40, 0, 0);
        train(32'h40, 32'h40, 1, 32'h100);
        fetch(32'h40);
        cyc(32'h100, 1, 0, 0, 0, 0, 0, 0);
        cyc(32'h40, 1, 0, 0, 1, 32'h40, 1, 32'h300);
        fetch(32'h40);

        for (int i = 0; i < 400; i++) begin
            cyc(rpick(), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0), $urandom() & ~32'h3,
                $urandom_range(0, 1) == 1, rpick(),
                $urandom_range(0, 1) == 1, $urandom() & ~32'h3);
        end

        train(32'h0, 32'h40, 1, 32'h300);
        train(32'h0, 32'h40, 1, 32'h300);
        fetch(32'h40);
        @(posedge clock);
        #2;
        reset = 0;
        inst_address = 32'h40; stall = 0; redirect_valid = 0; upd_valid = 0;
        #1;
        model_reset();
        chk("async_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("async_rst_pred_target", pred_target, 32'd0);
        chk("async_rst_next_pc", next_pc, 32'h44);
        @(negedge clock);
        #1 reset = 1;
        fetch(32'h40);
        fetch(32'h44);

        repeat (4) @(posedge clock);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
